icache_2way: RTL and testbench

Parametrised 2-way set-associative instruction cache with multi-word lines and an internal refill state machine. It sits between the instruction-fetch stage and the memory controller. It returns hits one cycle after the request and refills missing lines word-by-word over a request/valid handshake. It also supports pseudo-LRU replacement, whole-cache flush (fence.i), fetch redirect during refill, and the global `rdy` stall.

---
 rtl/icache_2way.sv | 198 +++++++++++++++++++
 tb/tb_icache_2way.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache with word-by-word refill FSM.
// Ports: clk/rst/rdy, flush, if_req/if_addr -> if_valid/if_data, busy, mem_req/mem_addr <- mem_valid/mem_data.
module icache_2way #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int SETS  = 1 << INDEX_W;
  localparam int LW    = 1 << OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    RESP
  } state_t;

  state_t state, state_n;

  logic [SETS-1:0]   vld0, vld1, lru;
  logic [TAG_W-1:0]  tag0 [SETS];
  logic [TAG_W-1:0]  tag1 [SETS];
  logic [DATA_W-1:0] dat0 [SETS*LW];
  logic [DATA_W-1:0] dat1 [SETS*LW];

  logic [INDEX_W-1:0]  lk_idx, rq_idx;
  logic [OFFSET_W-1:0] lk_off, rq_off, cnt;
  logic [TAG_W-1:0]    lk_tag;
  logic                victim, vsel;
  // drop: no response owed; kill: line must not be installed
  logic                drop, kill;
  logic                hit0, hit1, last;
  logic [DATA_W-1:0]   rd0, rd1, rsp_word;
  logic                do_hit, do_miss, do_fill;
  logic                do_inst, do_resp;
  logic                unused_addr;

  assign lk_off = if_addr[OFFSET_W+1:2];
  assign lk_idx = if_addr[OFFSET_W+2 +: INDEX_W];
  assign lk_tag = if_addr[ADDR_W-1 -: TAG_W];
  assign unused_addr = ^if_addr[1:0];

  assign hit0 = vld0[lk_idx] && (tag0[lk_idx] == lk_tag);
  assign hit1 = vld1[lk_idx] && (tag1[lk_idx] == lk_tag);
  assign rd0  = dat0[{lk_idx, lk_off}];
  assign rd1  = dat1[{lk_idx, lk_off}];

  // Fill invalid ways first, then fall back to LRU
  assign vsel = !vld0[lk_idx] ? 1'b0 :
                !vld1[lk_idx] ? 1'b1 :
                lru[lk_idx];

  assign rsp_word = victim ? dat1[{rq_idx, rq_off}]
                           : dat0[{rq_idx, rq_off}];

  assign last = (cnt == {OFFSET_W{1'b1}});
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    do_hit  = 1'b0;
    do_miss = 1'b0;
    do_fill = 1'b0;
    do_inst = 1'b0;
    do_resp = 1'b0;
    if (rdy) begin
      unique case (state)
        IDLE: begin
          if (if_req && !flush) begin
            if (hit0 || hit1) begin
              do_hit = 1'b1;
            end else begin
              do_miss = 1'b1;
              state_n = REFILL;
            end
          end
        end
        REFILL: begin
          if (mem_valid && mem_req) begin
            do_fill = 1'b1;
            if (last) state_n = RESP;
          end
        end
        RESP: begin
          state_n = IDLE;
          do_inst = !kill && !flush;
          do_resp = !kill && !flush && !drop;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld0     <= '0;
      vld1     <= '0;
      lru      <= '0;
      if_valid <= 1'b0;
      if_data  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      rq_idx   <= '0;
      rq_off   <= '0;
      cnt      <= '0;
      victim   <= 1'b0;
      drop     <= 1'b0;
      kill     <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      if (rdy) begin
        if (do_hit) begin
          if_valid    <= 1'b1;
          if_data     <= hit1 ? rd1 : rd0;
          lru[lk_idx] <= hit0;
        end
        if (do_miss) begin
          rq_idx   <= lk_idx;
          rq_off   <= lk_off;
          victim   <= vsel;
          cnt      <= '0;
          drop     <= 1'b0;
          kill     <= 1'b0;
          mem_req  <= 1'b1;
          mem_addr <= {if_addr[ADDR_W-1:OFFSET_W+2],
                       {(OFFSET_W+2){1'b0}}};
          // a half-written line must never hit
          if (vsel) vld1[lk_idx] <= 1'b0;
          else      vld0[lk_idx] <= 1'b0;
        end
        if (do_fill) begin
          cnt      <= cnt + OFFSET_W'(1);
          mem_addr <= mem_addr + ADDR_W'(4);
          if (last) mem_req <= 1'b0;
        end
        if (state == REFILL && !if_req) begin
          drop <= 1'b1;
        end
        if (do_inst) begin
          if (victim) vld1[rq_idx] <= 1'b1;
          else        vld0[rq_idx] <= 1'b1;
          lru[rq_idx] <= ~victim;
        end
        if (do_resp) begin
          if_valid <= 1'b1;
          if_data  <= rsp_word;
        end
        if (flush) begin
          vld0 <= '0;
          vld1 <= '0;
          if (state != IDLE) begin
            drop <= 1'b1;
            kill <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_miss) begin
      if (vsel) tag1[lk_idx] <= lk_tag;
      else      tag0[lk_idx] <= lk_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_fill) begin
      if (victim) dat1[{rq_idx, cnt}] <= mem_data;
      else        dat0[{rq_idx, cnt}] <= mem_data;
    end
  end

endmodule

// File: tb/tb_icache_2way.sv
// Scoreboard bench for icache_2way: directed fetches against a 3-cycle memory model.
// Expected fetch words and refill addresses are queued at issue, checked by monitors.
module tb_icache_2way;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, if_req;
  logic [31:0] if_addr;
  logic        if_valid, busy, mem_req, mem_valid;
  logic [31:0] if_data, mem_addr, mem_data;

  always #5 clk = ~clk;

  icache_2way dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_data   (if_data),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_data  (mem_data)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          fire_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_mem[$];

  function automatic logic [31:0] mword(input logic [31:0] a);
    return a ^ 32'hC3A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:4], 4'h0};
    for (int i = 0; i < 4; i++) exp_mem.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_fires(input int target);
    int cyc;
    cyc = 0;
    while (fire_cnt < target && cyc < 200) begin
      tick();
      cyc++;
    end
    if (cyc >= 200) chk("fire_timeout", 32'(fire_cnt), 32'(target));
  endtask

  task automatic fetch(input string nm, input logic [31:0] a,
                       input bit miss, input bit fl, input int want);
    int cyc;
    cyc = 0;
    if (miss) push_line(a);
    exp_q.push_back(mword({a[31:2], 2'b00}));
    if_addr = a;
    if_req  = 1'b1;
    flush   = fl;
    do begin
      tick();
      cyc++;
      flush = 1'b0;
    end while (!if_valid && cyc < 200);
    if_req = 1'b0;
    chk({nm, "_latency"}, 32'(cyc), 32'(want));
    if (!miss) chk({nm, "_no_memreq"}, {31'b0, mem_req}, 32'd0);
  endtask

  // memory model: each word returned on the 3rd sampled cycle of mem_req
  initial begin
    int lat;
    logic [31:0] e;
    lat = 0;
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (!rst || !mem_req) begin
        lat = 0;
      end else if (rdy) begin
        if (lat == 2) begin
          lat = 0;
          mem_valid = 1'b1;
          mem_data  = mword(mem_addr);
          fire_cnt++;
          n_tests++;
          if (exp_mem.size() == 0) begin
            n_fail++;
            $display("FAIL mem_addr_unexpected: got %h, want none", mem_addr);
          end else begin
            e = exp_mem.pop_front();
            if (mem_addr !== e) begin
              n_fail++;
              $display("FAIL mem_addr_seq: got %h, want %h", mem_addr, e);
            end
          end
        end else begin
          lat++;
        end
      end
    end
  end

  // response monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (if_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL if_valid_unexpected: got %h, want none", if_data);
        end else begin
          e = exp_q.pop_front();
          if (if_data !== e) begin
            n_fail++;
            $display("FAIL if_data: got %h, want %h", if_data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int cyc;
    rst = 1'b0;
    rdy = 1'b1;
    flush = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    tick();
    tick();
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;

    fetch("cold100", 32'h100, 1, 0, 14);
    fetch("hit108", 32'h108, 0, 0, 1);

    fetch("c500", 32'h500, 1, 0, 14);
    fetch("c100", 32'h100, 0, 0, 1);
    fetch("c900", 32'h900, 1, 0, 14);
    fetch("c104", 32'h104, 0, 0, 1);
    fetch("c500b", 32'h500, 1, 0, 14);

    fetch("flush100", 32'h100, 1, 1, 15);

    // redirect after the second word
    start = fire_cnt;
    push_line(32'h200);
    if_addr = 32'h200;
    if_req = 1'b1;
    wait_fires(start + 2);
    if_req = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("drop_words", 32'(fire_cnt - start), 32'd4);
    tick();
    tick();
    fetch("drop_hit204", 32'h204, 0, 0, 1);

    // freeze mid-refill
    start = fire_cnt;
    push_line(32'h30C);
    exp_q.push_back(mword(32'h30C));
    if_addr = 32'h30C;
    if_req = 1'b1;
    wait_fires(start + 1);
    rdy = 1'b0;
    chk("frz_addr0", mem_addr, 32'h304);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_mem_addr", mem_addr, 32'h304);
      chk("frz_mem_req", {31'b0, mem_req}, 32'd1);
      chk("frz_if_valid", {31'b0, if_valid}, 32'd0);
    end
    rdy = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!if_valid && cyc < 200);
    if_req = 1'b0;
    chk("frz_words", 32'(fire_cnt - start), 32'd4);

    // reset mid-refill
    start = fire_cnt;
    push_line(32'h404);
    if_addr = 32'h404;
    if_req = 1'b1;
    wait_fires(start + 2);
    rst = 1'b0;
    if_req = 1'b0;
    tick();
    chk("rrst_busy", {31'b0, busy}, 32'd0);
    chk("rrst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rrst_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
    exp_mem.delete();
    fetch("rrst_miss404", 32'h404, 1, 0, 14);

    tick();
    tick();
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("mem_drained", 32'(exp_mem.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
